// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_PASS_A = 4'h0;
  localparam logic [3:0] OP_PASS_B = 4'h1;
  localparam logic [3:0] OP_NOT_A  = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_OR     = 4'h4;
  localparam logic [3:0] OP_XOR    = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_ADDC   = 4'h7;
  localparam logic [3:0] OP_INC_A  = 4'h8;
  localparam logic [3:0] OP_DEC_A  = 4'h9;
  localparam logic [3:0] OP_SHL_A  = 4'hA;
  localparam logic [3:0] OP_SHR_A  = 4'hB;
  localparam logic [3:0] OP_ROL_A  = 4'hC;
  localparam logic [3:0] OP_ASR_A  = 4'hD;
  localparam logic [3:0] OP_MUL_LO = 4'hE;
  localparam logic [3:0] OP_MUL_HI = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL_LO) || (op == OP_MUL_HI);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
// prod carries the product including the step in progress, so it is final while done is high.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_step;

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy = busy_q;
  assign prod = acc_step;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative multiplier.
// States: S_IDLE waiting for an op | S_MUL multiply in progress | S_DONE result presented.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic [3:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v
);

  localparam int MSB = WIDTH - 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [3:0]         flags_q, flags_d;
  logic [3:0]         sel_q, sel_d;

  logic               accept, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   op_y, fin_y;
  logic               op_c, op_v, fin_c, fin_v;
  logic [3:0]         fin_flags;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    ext  = '0;
    op_y = '0;
    op_c = 1'b0;
    op_v = 1'b0;
    case (sel)
      OP_PASS_A: op_y = a;
      OP_PASS_B: op_y = b;
      OP_NOT_A:  op_y = ~a;
      OP_AND:    op_y = a & b;
      OP_OR:     op_y = a | b;
      OP_XOR:    op_y = a ^ b;
      OP_SUB: begin
        ext  = {1'b0, a} - {1'b0, b};
        op_y = ext[WIDTH-1:0];
        op_c = ext[WIDTH];
        op_v = (a[MSB] ^ b[MSB]) & (op_y[MSB] ^ a[MSB]);
      end
      OP_ADDC: begin
        ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        op_y = ext[WIDTH-1:0];
        op_c = ext[WIDTH];
        op_v = ~(a[MSB] ^ b[MSB]) & (op_y[MSB] ^ a[MSB]);
      end
      OP_INC_A: begin
        ext  = {1'b0, a} + (WIDTH+1)'(1);
        op_y = ext[WIDTH-1:0];
        op_c = ext[WIDTH];
        op_v = ~a[MSB] & op_y[MSB];
      end
      OP_DEC_A: begin
        ext  = {1'b0, a} - (WIDTH+1)'(1);
        op_y = ext[WIDTH-1:0];
        op_c = ext[WIDTH];
        op_v = a[MSB] & ~op_y[MSB];
      end
      OP_SHL_A: begin op_y = {a[MSB-1:0], 1'b0};   op_c = a[MSB]; end
      OP_SHR_A: begin op_y = {1'b0, a[MSB:1]};     op_c = a[0];   end
      OP_ROL_A: begin op_y = {a[MSB-1:0], a[MSB]}; op_c = a[MSB]; end
      OP_ASR_A: begin op_y = {a[MSB], a[MSB:1]};   op_c = a[0];   end
      default: begin
        op_y = '0;
      end
    endcase
  end

  // A multiply completes from the latched opcode; everything else from the live inputs.
  always_comb begin
    if (state_q == S_MUL) begin
      if (sel_q == OP_MUL_HI) begin
        fin_y = mul_prod[2*WIDTH-1:WIDTH];
        fin_c = |mul_prod[WIDTH-1:0];
      end else begin
        fin_y = mul_prod[WIDTH-1:0];
        fin_c = |mul_prod[2*WIDTH-1:WIDTH];
      end
      fin_v = 1'b0;
    end else begin
      fin_y = op_y;
      fin_c = op_c;
      fin_v = op_v;
    end
    fin_flags         = '0;
    fin_flags[FLAG_Z] = (fin_y == '0);
    fin_flags[FLAG_N] = fin_y[MSB];
    fin_flags[FLAG_C] = fin_c;
    fin_flags[FLAG_V] = fin_v;
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    flags_d   = flags_q;
    sel_d     = sel_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_mul_op(sel)) begin
            sel_d     = sel;
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            y_d     = fin_y;
            flags_d = fin_flags;
            state_d = S_DONE;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          y_d     = fin_y;
          flags_d = fin_flags;
          state_d = S_DONE;
        end else if (!mul_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      flags_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: vector table plus handshake, stall and reset sequences.
module tb_alu_pipe;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] y;
    logic [3:0] f;   // {z, n, c, v}
  } vec_t;

  localparam int NVEC = 27;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [3:0] sel;
  logic       flag_z, flag_n, flag_c, flag_v;
  logic [3:0] flags_act;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [0:NVEC-1];

  assign flags_act = {flag_z, flag_n, flag_c, flag_v};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  function automatic vec_t mk(input logic [3:0] s, input logic [7:0] va, input logic [7:0] vb,
                              input logic vc, input logic [7:0] vy, input logic [3:0] vf);
    vec_t v;
    v.sel = s; v.a = va; v.b = vb; v.cin = vc; v.y = vy; v.f = vf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sel = v.sel; a = v.a; b = v.b; cin = v.cin;
  endtask

  // Issue one op with out_ready=1, measure accept-to-out_valid latency and check the result.
  task automatic run_op(input vec_t v, input string nm);
    int  lat, waits;
    bit  stalled_ok;
    bit  is_mul;
    is_mul = (v.sel == 4'hE) || (v.sel == 4'hF);
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk({nm, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    stalled_ok = 1'b1;
    while (!out_valid && lat < 30) begin
      if (in_ready) stalled_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, "_lat"}, 32'(lat), is_mul ? 32'd9 : 32'd1);
    chk({nm, "_y"}, 32'(y), 32'(v.y));
    chk({nm, "_flags"}, 32'(flags_act), 32'(v.f));
    if (is_mul) chk({nm, "_busy_in_ready"}, 32'(stalled_ok), 32'd1);
  endtask

  initial begin
    int  seen;
    // a=93 b=A7 cin=1 across all opcodes, then boundary vectors.
    tbl[0]  = mk(4'h0, 8'h93, 8'hA7, 1'b1, 8'h93, 4'b0100);
    tbl[1]  = mk(4'h1, 8'h93, 8'hA7, 1'b1, 8'hA7, 4'b0100);
    tbl[2]  = mk(4'h2, 8'h93, 8'hA7, 1'b1, 8'h6C, 4'b0000);
    tbl[3]  = mk(4'h3, 8'h93, 8'hA7, 1'b1, 8'h83, 4'b0100);
    tbl[4]  = mk(4'h4, 8'h93, 8'hA7, 1'b1, 8'hB7, 4'b0100);
    tbl[5]  = mk(4'h5, 8'h93, 8'hA7, 1'b1, 8'h34, 4'b0000);
    tbl[6]  = mk(4'h6, 8'h93, 8'hA7, 1'b1, 8'hEC, 4'b0110);
    tbl[7]  = mk(4'h7, 8'h93, 8'hA7, 1'b1, 8'h3B, 4'b0011);
    tbl[8]  = mk(4'h8, 8'h93, 8'hA7, 1'b1, 8'h94, 4'b0100);
    tbl[9]  = mk(4'h9, 8'h93, 8'hA7, 1'b1, 8'h92, 4'b0100);
    tbl[10] = mk(4'hA, 8'h93, 8'hA7, 1'b1, 8'h26, 4'b0010);
    tbl[11] = mk(4'hB, 8'h93, 8'hA7, 1'b1, 8'h49, 4'b0010);
    tbl[12] = mk(4'hC, 8'h93, 8'hA7, 1'b1, 8'h27, 4'b0010);
    tbl[13] = mk(4'hD, 8'h93, 8'hA7, 1'b1, 8'hC9, 4'b0110);
    tbl[14] = mk(4'hE, 8'h93, 8'hA7, 1'b1, 8'hE5, 4'b0110);
    tbl[15] = mk(4'hF, 8'h93, 8'hA7, 1'b1, 8'h5F, 4'b0010);
    tbl[16] = mk(4'h8, 8'h7F, 8'h00, 1'b0, 8'h80, 4'b0101);
    tbl[17] = mk(4'h8, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b1010);
    tbl[18] = mk(4'h9, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0110);
    tbl[19] = mk(4'h9, 8'h80, 8'h00, 1'b0, 8'h7F, 4'b0001);
    tbl[20] = mk(4'h7, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0101);
    tbl[21] = mk(4'h6, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000);
    tbl[22] = mk(4'hE, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b0010);
    tbl[23] = mk(4'hF, 8'hFF, 8'hFF, 1'b0, 8'hFE, 4'b0110);
    tbl[24] = mk(4'hE, 8'h00, 8'h5A, 1'b0, 8'h00, 4'b1000);
    tbl[25] = mk(4'h7, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
    tbl[26] = mk(4'h6, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 4'h0; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'(flags_act), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back sweep of single-cycle opcodes: one result per edge.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i]);
      in_valid = 1'b1;
      chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_y", i), 32'(y), 32'(tbl[i].y));
      chk($sformatf("b2b%0d_flags", i), 32'(flags_act), 32'(tbl[i].f));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("b2b_drain_valid", 32'(out_valid), 32'd0);

    // Output stall: ADDC held for 5 cycles while XOR waits, then released.
    @(negedge clk);
    drive(tbl[7]);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 drive(tbl[5]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_y", i), 32'(y), 32'h3B);
      chk($sformatf("stall%0d_flags", i), 32'(flags_act), 32'(4'b0011));
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_y", 32'(y), 32'h34);
    chk("release_flags", 32'(flags_act), 32'(4'b0000));
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("release_drain_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    drive(tbl[14]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("mulrst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mulrst_valid", 32'(out_valid), 32'd0);
    chk("mulrst_y", 32'(y), 32'd0);
    chk("mulrst_flags", 32'(flags_act), 32'd0);
    chk("mulrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("mulrst_no_result", 32'(seen), 32'd0);
    run_op(tbl[3], "post_rst_and");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Keeps the 4-bit sel opcode space and carry-in.
- Adds generic WIDTH, valid/ready handshakes on input and output, status flags, and a multi-cycle iterative unsigned multiplier.
- Sits between the MiniCPU decode stage (operand issue) and writeback; stalls decode via in_ready while busy.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH)+1: multiplier iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used by ADDC only
- sel  in  4  opcode
- out_valid  out  1  y/flags valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- flag_z  out  1  y == 0
- flag_n  out  1  y[WIDTH-1]
- flag_c  out  1  carry/borrow/shift-out (per op)
- flag_v  out  1  signed overflow (add/sub/inc/dec only, else 0)

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE; out_valid=0; y=0; all flags 0; multiplier registers cleared.
  - Applies from any state; an in-flight multiply is discarded.
- Opcodes:
  - 0 PASS_A, 1 PASS_B, 2 NOT_A, 3 AND, 4 OR, 5 XOR.
  - 6 SUB a-b; C=1 on unsigned borrow.
  - 7 ADDC a+b+cin; C=carry out.
  - 8 INC_A; C=carry out.
  - 9 DEC_A; C=borrow.
  - A SHL_A by 1; C=a[MSB].
  - B SHR_A logical; C=a[0].
  - C ROL_A; C=a[MSB].
  - D ASR_A; C=a[0].
  - E MUL_LO: low WIDTH bits of unsigned a*b.
  - F MUL_HI: high WIDTH bits of unsigned a*b.
  - C=0 for opcodes 0-5.
  - V for 6-9 uses standard two's-complement overflow of WIDTH-bit operands.
  - MUL: C = (other half != 0), V=0.
- Arithmetic: internal add/sub at WIDTH+1 bits; y truncated to WIDTH. Multiply product is 2*WIDTH bits.
- FSM states:
  - IDLE: accept when in_valid && in_ready.
    - Opcodes 0-D: y/flags registered at the accept edge → DONE (latency 1).
    - E/F: latch a, b, sel → MUL with counter=0.
  - MUL: one shift-add step per cycle. After WIDTH steps, load y/flags from the product half selected by latched sel → DONE. Multiply latency is WIDTH+1 cycles from accept to out_valid (9 for WIDTH=8).
  - DONE: out_valid=1; y and flags held stable until out_ready.
    - out_ready && in_valid: new op accepted in the same cycle (back-to-back, throughput 1/cycle for 0-D).
    - out_ready && !in_valid: → IDLE, out_valid=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from out_ready; no other combinational in→out paths.
- in_valid in MUL is ignored (in_ready=0); the op is not lost because the producer must hold it.
- Output registers change only on a completing edge; outputs are never glitched mid-MUL.
- Opcodes E/F accepted from DONE follow the MUL path as from IDLE.

Decomposition:
- Package alu_pkg: localparam opcode constants (OP_PASS_A .. OP_MUL_HI), FSM state enum (S_IDLE, S_MUL, S_DONE), flag index constants.
- One sub-module: alu_mul_iter (start, a, b → busy, done, prod[2*WIDTH-1:0]), shift-add, WIDTH cycles.
- Combinational ops live in the top as a single case.

Test Plan (WIDTH=8, a=8'h93, b=8'hA7):
- ADDC, cin=1, out_ready=1 → out_valid one cycle after accept; y=8'h3B, C=1, V=1, Z=0, N=0.
- SUB → y=8'hEC, C=1 (borrow), V=0, N=1. XOR → y=8'h34, C=0.
- MUL_LO then MUL_HI → y=8'hE5 with C=1, then y=8'h5F with C=1. Each out_valid exactly 9 cycles after accept; in_ready=0 throughout MUL.
- Sweep sel 0..F back-to-back with out_ready=1 → one result per cycle for 0-D; every y/flag matches a reference model; no op dropped or duplicated.
- Hold out_ready=0 for 5 cycles after ADDC → y/flags/out_valid stable; in_ready=0. Release → next op accepted on the same edge.
- Drive rst_n=0 for one edge at MUL cycle 4 → next cycle state IDLE, out_valid=0, y=0, in_ready=1. A following AND gives y=8'h83.
